fdd_drive_status: RTL and testbench



---
 rtl/fdd_pkg.sv | 17 +
 rtl/fdd_bus_sync.sv | 48 ++++
 rtl/fdd_drive_status.sv | 158 +++++++++++++++
 tb/tb_fdd_drive_status.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdd_pkg.sv
// Shared constants and helpers for the floppy drive status emulation.
package fdd_pkg;

  // Default head-track geometry (80-track drive).
  localparam int TRACK_W_DEF   = 7;
  localparam int MAX_TRACK_DEF = 79;

  // Floppy bus lines are open-collector, active-low.
  localparam logic BUS_ACTIVE = 1'b0;
  localparam logic BUS_IDLE   = 1'b1;

  // Converts a duration in microseconds to clock cycles using 32-bit integer math.
  function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
    return (clk_hz / 32'd1000000) * us;
  endfunction

endpackage

// File: rtl/fdd_bus_sync.sv
// Two-flop synchroniser for one asynchronous floppy bus line, with an
// optional falling-edge detector on the synchronised value.
module fdd_bus_sync #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;

  // Bus lines idle high, so the synchroniser resets to the released level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

  generate
    if (EDGE_EN) begin : g_edge
      logic r_prev;

      // Delayed copy of the synchronised line for the 1->0 detector.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_prev <= 1'b1;
        end else begin
          r_prev <= r_sync;
        end
      end

      assign o_fall = r_prev & ~r_sync;
    end else begin : g_no_edge
      assign o_fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/fdd_drive_status.sv
// Floppy drive mechanics emulation: head track register, synthetic index
// pulse, and the four bus status outputs (index, track 00, write protect,
// disk change). Define DSK_CHG_EN to build the disk-change latch; without it
// dsk_chg_n is tied released so an external jumper can report READY.
module fdd_drive_status
  import fdd_pkg::*;
#(
  parameter int CLK_HZ        = 12000000,
  parameter int ROT_PERIOD_US = 200000,
  parameter int INDEX_US      = 4000,
  parameter int MAX_TRACK     = MAX_TRACK_DEF,
  parameter int TRACK_W       = TRACK_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               drive_sel_n,
  input  logic               motor_on_n,
  input  logic               dir_n,
  input  logic               step_n,
  input  logic               disk_in,
  input  logic               wp_in,
  output logic               index_n,
  output logic               track0_n,
  output logic               wr_protect_n,
  output logic               dsk_chg_n,
  output logic [TRACK_W-1:0] track,
  output logic               rev_strobe
);

  localparam int unsigned ROT_CYC = us_to_cycles(CLK_HZ, ROT_PERIOD_US);
  localparam int unsigned IDX_CYC = us_to_cycles(CLK_HZ, INDEX_US);
  localparam int          CNT_W   = $clog2(ROT_CYC);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ROT_CYC - 1);
  localparam logic [TRACK_W-1:0] TRK_MAX  = TRACK_W'(MAX_TRACK);

  logic w_sel_n_s, w_motor_n_s, w_dir_n_s, w_step_n_s;
  logic w_step_fall, w_sel_fall, w_motor_fall, w_dir_fall;
  logic w_unused_falls;
  logic w_sel, w_spin, w_step_evt, w_step_in, w_idx_raw;

  logic [TRACK_W-1:0] r_track;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rev_strobe;
  logic               r_index_n, r_track0_n, r_wr_protect_n;

  fdd_bus_sync #(.EDGE_EN(1'b1)) u_sync_step (
    .clk(clk), .rst_n(rst_n), .i_async(step_n), .o_sync(w_step_n_s), .o_fall(w_step_fall)
  );
  fdd_bus_sync #(.EDGE_EN(1'b0)) u_sync_sel (
    .clk(clk), .rst_n(rst_n), .i_async(drive_sel_n), .o_sync(w_sel_n_s), .o_fall(w_sel_fall)
  );
  fdd_bus_sync #(.EDGE_EN(1'b0)) u_sync_motor (
    .clk(clk), .rst_n(rst_n), .i_async(motor_on_n), .o_sync(w_motor_n_s), .o_fall(w_motor_fall)
  );
  fdd_bus_sync #(.EDGE_EN(1'b0)) u_sync_dir (
    .clk(clk), .rst_n(rst_n), .i_async(dir_n), .o_sync(w_dir_n_s), .o_fall(w_dir_fall)
  );

  // Only the step line needs its edge; the level of step_n itself is not used.
  assign w_unused_falls = &{1'b0, w_sel_fall, w_motor_fall, w_dir_fall, w_step_n_s};

  assign w_sel      = ~w_sel_n_s;
  assign w_spin     = ~w_motor_n_s & disk_in;
  assign w_step_evt = w_step_fall & w_sel;
  assign w_step_in  = ~w_dir_n_s;
  assign w_idx_raw  = w_spin & (32'(r_cnt) < IDX_CYC);

  // Head position: one track per step event, clamped at both ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_track <= '0;
    end else if (w_step_evt) begin
      if (w_step_in) begin
        if (r_track < TRK_MAX) r_track <= r_track + TRACK_W'(1);
      end else if (r_track != '0) begin
        r_track <= r_track - TRACK_W'(1);
      end
    end
  end

  // Rotation phase counter; frozen while not spinning, strobes on each wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_rev_strobe <= 1'b0;
    end else if (w_spin) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt        <= '0;
        r_rev_strobe <= 1'b1;
      end else begin
        r_cnt        <= r_cnt + CNT_W'(1);
        r_rev_strobe <= 1'b0;
      end
    end else begin
      r_rev_strobe <= 1'b0;
    end
  end

  // Registered bus drivers: driven while selected, released otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_index_n      <= BUS_IDLE;
      r_track0_n     <= BUS_IDLE;
      r_wr_protect_n <= BUS_IDLE;
    end else if (w_sel) begin
      r_index_n      <= w_idx_raw ? BUS_ACTIVE : BUS_IDLE;
      r_track0_n     <= (r_track == '0) ? BUS_ACTIVE : BUS_IDLE;
      r_wr_protect_n <= (wp_in | ~disk_in) ? BUS_ACTIVE : BUS_IDLE;
    end else begin
      r_index_n      <= BUS_IDLE;
      r_track0_n     <= BUS_IDLE;
      r_wr_protect_n <= BUS_IDLE;
    end
  end

`ifdef DSK_CHG_EN
  logic r_disk_d;
  logic r_chg;
  logic r_dsk_chg_n;

  // Disk-change latch: set on eject (wins), cleared by a step with a disk present.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_disk_d <= 1'b0;
      r_chg    <= 1'b1;
    end else begin
      r_disk_d <= disk_in;
      if (r_disk_d & ~disk_in) begin
        r_chg <= 1'b1;
      end else if (w_step_evt & disk_in) begin
        r_chg <= 1'b0;
      end
    end
  end

  // Disk-change bus driver, released while deselected.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dsk_chg_n <= BUS_ACTIVE;
    end else if (w_sel) begin
      r_dsk_chg_n <= r_chg ? BUS_ACTIVE : BUS_IDLE;
    end else begin
      r_dsk_chg_n <= BUS_IDLE;
    end
  end

  assign dsk_chg_n = r_dsk_chg_n;
`else
  assign dsk_chg_n = BUS_IDLE;
`endif

  assign index_n      = r_index_n;
  assign track0_n     = r_track0_n;
  assign wr_protect_n = r_wr_protect_n;
  assign track        = r_track;
  assign rev_strobe   = r_rev_strobe;

endmodule

// File: tb/tb_fdd_drive_status.sv
// Self-checking bench for fdd_drive_status using scaled rotation timing
// (100-cycle revolution, 4-cycle index). Works with or without DSK_CHG_EN.
`timescale 1ns/1ps
module tb_fdd_drive_status;

  localparam int TW   = 7;
  localparam int MAXT = 79;

`ifdef DSK_CHG_EN
  localparam logic CHG_LATCHED = 1'b0;
`else
  localparam logic CHG_LATCHED = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n, drive_sel_n, motor_on_n, dir_n, step_n, disk_in, wp_in;
  logic index_n, track0_n, wr_protect_n, dsk_chg_n, rev_strobe;
  logic [TW-1:0] track;

  int n_vec = 0;
  int n_err = 0;
  int exp_track = 0;
  logic [TW-1:0] exp_q[$];
  logic [1:0]    exp_ir_q[$];

  always #5 clk = ~clk;

  fdd_drive_status #(
    .CLK_HZ(1000000), .ROT_PERIOD_US(100), .INDEX_US(4), .MAX_TRACK(MAXT), .TRACK_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .drive_sel_n(drive_sel_n), .motor_on_n(motor_on_n),
    .dir_n(dir_n), .step_n(step_n), .disk_in(disk_in), .wp_in(wp_in),
    .index_n(index_n), .track0_n(track0_n), .wr_protect_n(wr_protect_n),
    .dsk_chg_n(dsk_chg_n), .track(track), .rev_strobe(rev_strobe)
  );

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One step pulse; the model result is queued when the pulse is driven.
  task automatic do_step();
    if (!drive_sel_n) begin
      if (!dir_n) begin
        if (exp_track < MAXT) exp_track++;
      end else if (exp_track > 0) begin
        exp_track--;
      end
    end
    exp_q.push_back(TW'(exp_track));
    step_n = 1'b0;
    tick(3);
    step_n = 1'b1;
    tick(3);
  endtask

  task automatic step_and_check(input string name);
    logic [TW-1:0] e;
    do_step();
    e = exp_q.pop_front();
    n_vec++;
    if (track !== e) begin
      n_err++;
      $display("FAIL %s: track got %0d expected %0d", name, track, e);
    end else begin
      $display("step %s: track %0d", name, track);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drive_sel_n = 1'b0; motor_on_n = 1'b1; dir_n = 1'b1;
    step_n = 1'b1; disk_in = 1'b1; wp_in = 1'b0;
    tick(3);
    n_vec++;
    if ({track, index_n, track0_n, wr_protect_n, dsk_chg_n, rev_strobe} !==
        {7'd0, 1'b1, 1'b1, 1'b1, CHG_LATCHED, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: trk=%0d idx=%b t0=%b wp=%b chg=%b rev=%b expected 0 1 1 1 %b 0",
               track, index_n, track0_n, wr_protect_n, dsk_chg_n, rev_strobe, CHG_LATCHED);
    end
    rst_n = 1'b1;
    tick(4);
    n_vec++;
    if ({track0_n, wr_protect_n, dsk_chg_n, index_n} !== {1'b0, 1'b1, CHG_LATCHED, 1'b1}) begin
      n_err++;
      $display("FAIL selected_idle: t0=%b wp=%b chg=%b idx=%b expected 0 1 %b 1",
               track0_n, wr_protect_n, dsk_chg_n, index_n, CHG_LATCHED);
    end
    $display("reset: track %0d track0_n %b dsk_chg_n %b", track, track0_n, dsk_chg_n);
  endtask

  task automatic test_step_in();
    dir_n = 1'b0;
    tick(3);
    step_n = 1'b0;
    tick(2);
    n_vec++;
    if (track !== 7'd0) begin
      n_err++;
      $display("FAIL step_latency_early: track got %0d expected 0", track);
    end
    tick(1);
    exp_track = 1;
    n_vec++;
    if (track !== 7'd1) begin
      n_err++;
      $display("FAIL step_latency: track got %0d expected 1", track);
    end
    step_n = 1'b1;
    tick(3);
    n_vec++;
    if (dsk_chg_n !== 1'b1) begin
      n_err++;
      $display("FAIL chg_cleared: dsk_chg_n got %b expected 1", dsk_chg_n);
    end
    for (int i = 0; i < 4; i++) step_and_check("in");
    n_vec++;
    if (track0_n !== 1'b1) begin
      n_err++;
      $display("FAIL track0_off: track0_n got %b expected 1", track0_n);
    end
  endtask

  task automatic test_step_limits();
    dir_n = 1'b1;
    tick(3);
    for (int i = 0; i < 7; i++) step_and_check("out");
    n_vec++;
    if (track0_n !== 1'b0) begin
      n_err++;
      $display("FAIL track0_on: track0_n got %b expected 0", track0_n);
    end
    dir_n = 1'b0;
    tick(3);
    for (int i = 0; i < 85; i++) step_and_check("in_max");
  endtask

  task automatic test_index();
    int found;
    int bad;
    int first;
    int ph;
    logic [1:0] e;
    motor_on_n = 1'b0;
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      tick(1);
      if (rev_strobe === 1'b1) found = 1;
    end
    n_vec++;
    if (found == 0) begin
      n_err++;
      $display("FAIL first_rev: no rev_strobe within 300 cycles, expected one");
    end
    // Sample j=0 is the strobe cycle (phase 0); index_n reflects the previous phase.
    for (int j = 0; j < 300; j++) begin
      ph = (j + 99) % 100;
      exp_ir_q.push_back({(ph < 4) ? 1'b0 : 1'b1, (j % 100 == 0) ? 1'b1 : 1'b0});
      e = exp_ir_q.pop_front();
      n_vec++;
      if ({index_n, rev_strobe} !== e) begin
        n_err++;
        $display("FAIL rotation cyc %0d: idx/rev got %b%b expected %b", j, index_n, rev_strobe, e);
      end
      tick(1);
    end
    $display("rotation: 300 cycles checked");
    // Phase 0 now; drop the motor so spin stops while the counter sits at 2.
    motor_on_n = 1'b1;
    tick(2);
    n_vec++;
    if (index_n !== 1'b0) begin
      n_err++;
      $display("FAIL idx_before_stop: index_n got %b expected 0", index_n);
    end
    tick(1);
    n_vec++;
    if (index_n !== 1'b1) begin
      n_err++;
      $display("FAIL idx_stop: index_n got %b expected 1", index_n);
    end
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      if (index_n !== 1'b1 || rev_strobe !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL stopped: %0d active idx/rev cycles, expected 0", bad);
    end
    motor_on_n = 1'b0;
    first = 0;
    for (int i = 1; i <= 150; i++) begin
      tick(1);
      if (i == 3) begin
        n_vec++;
        if (index_n !== 1'b0) begin
          n_err++;
          $display("FAIL idx_resume: index_n got %b expected 0", index_n);
        end
      end
      if (rev_strobe === 1'b1 && first == 0) first = i;
    end
    n_vec++;
    if (first != 100) begin
      n_err++;
      $display("FAIL frozen_phase: strobe after %0d cycles, expected 100", first);
    end
    $display("motor restart: strobe after %0d cycles", first);
  endtask

  task automatic test_deselect();
    int bad;
    int strobes;
    dir_n = 1'b1;
    tick(3);
    for (int i = 0; i < MAXT; i++) step_and_check("home");
    drive_sel_n = 1'b1;
    tick(2);
    n_vec++;
    if (track0_n !== 1'b0) begin
      n_err++;
      $display("FAIL desel_latency: track0_n got %b expected 0", track0_n);
    end
    tick(1);
    bad = 0;
    strobes = 0;
    for (int i = 0; i < 200; i++) begin
      if ({index_n, track0_n, wr_protect_n, dsk_chg_n} !== 4'b1111) bad++;
      if (rev_strobe === 1'b1) strobes++;
      tick(1);
    end
    n_vec++;
    if (bad != 0 || strobes != 2) begin
      n_err++;
      $display("FAIL deselected: %0d driven cycles, %0d strobes; expected 0 and 2", bad, strobes);
    end
    dir_n = 1'b0;
    tick(3);
    for (int i = 0; i < 5; i++) step_and_check("ignored");
  endtask

  task automatic test_disk_change();
    logic [TW-1:0] e;
    drive_sel_n = 1'b0;
    tick(4);
    step_and_check("pre_eject");
    n_vec++;
    if (dsk_chg_n !== 1'b1) begin
      n_err++;
      $display("FAIL chg_clear2: dsk_chg_n got %b expected 1", dsk_chg_n);
    end
    // Eject lands in the exact cycle the step event is decoded.
    exp_track++;
    exp_q.push_back(TW'(exp_track));
    step_n = 1'b0;
    tick(2);
    disk_in = 1'b0;
    tick(1);
    e = exp_q.pop_front();
    n_vec++;
    if (track !== e) begin
      n_err++;
      $display("FAIL eject_step: track got %0d expected %0d", track, e);
    end
    step_n = 1'b1;
    tick(1);
    n_vec++;
    if ({dsk_chg_n, wr_protect_n} !== {CHG_LATCHED, 1'b0}) begin
      n_err++;
      $display("FAIL eject: chg=%b wp=%b expected %b 0", dsk_chg_n, wr_protect_n, CHG_LATCHED);
    end
    tick(2);
    step_and_check("no_disk");
    n_vec++;
    if (dsk_chg_n !== CHG_LATCHED) begin
      n_err++;
      $display("FAIL chg_hold: dsk_chg_n got %b expected %b", dsk_chg_n, CHG_LATCHED);
    end
    disk_in = 1'b1; wp_in = 1'b1;
    tick(2);
    n_vec++;
    if (wr_protect_n !== 1'b0) begin
      n_err++;
      $display("FAIL wp_on: wr_protect_n got %b expected 0", wr_protect_n);
    end
    wp_in = 1'b0;
    tick(2);
    n_vec++;
    if (wr_protect_n !== 1'b1) begin
      n_err++;
      $display("FAIL wp_off: wr_protect_n got %b expected 1", wr_protect_n);
    end
    $display("disk change: track %0d dsk_chg_n %b", track, dsk_chg_n);
  endtask

  task automatic test_reset_mid();
    step_n = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    exp_track = 0;
    n_vec++;
    if ({track, index_n, track0_n, wr_protect_n, dsk_chg_n, rev_strobe} !==
        {7'd0, 1'b1, 1'b1, 1'b1, CHG_LATCHED, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid: trk=%0d idx=%b t0=%b wp=%b chg=%b rev=%b",
               track, index_n, track0_n, wr_protect_n, dsk_chg_n, rev_strobe);
    end
    step_n = 1'b1;
    rst_n = 1'b1;
    tick(4);
    n_vec++;
    if (track0_n !== 1'b0 || track !== 7'd0) begin
      n_err++;
      $display("FAIL after_reset: trk=%0d t0=%b expected 0 0", track, track0_n);
    end
    $display("reset mid-step: track %0d", track);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; drive_sel_n = 1'b1; motor_on_n = 1'b1; dir_n = 1'b1;
    step_n = 1'b1; disk_in = 1'b0; wp_in = 1'b0;
    test_reset();
    test_step_in();
    test_step_limits();
    test_index();
    test_deselect();
    test_disk_change();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
